// File: rtl/mux_8x1_select_sequencer.sv
// rtl/mux_8x1_select_sequencer.sv - byte-in, select-stepping driver that turns an 8x1 mux into a serialiser
module mux_8x1_select_sequencer #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       D0,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5,
  output logic       D6,
  output logic       D7,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       bit_valid,
  output logic       bit_strobe,
  output logic       done
);

  localparam int              DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(DIV - 1);
  localparam logic [2:0]      FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t        r_state;
  logic [7:0]    r_data;
  logic [2:0]    r_idx;
  logic [2:0]    r_bitcnt;
  logic [DW-1:0] r_divcnt;
  logic          r_bit_valid;
  logic          r_bit_strobe;
  logic          r_done;

  logic [2:0]    w_next_idx;
  logic          w_last_tick;

  assign w_next_idx  = MSB_FIRST ? (r_idx - 3'd1) : (r_idx + 3'd1);
  assign w_last_tick = (r_divcnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_data       <= 8'd0;
      r_idx        <= 3'd0;
      r_bitcnt     <= 3'd0;
      r_divcnt     <= '0;
      r_bit_valid  <= 1'b0;
      r_bit_strobe <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bit_strobe <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data       <= din;
            r_idx        <= FIRST_IDX;
            r_bitcnt     <= 3'd0;
            r_divcnt     <= '0;
            r_state      <= ST_SHIFT;
            r_bit_valid  <= 1'b1;
            r_bit_strobe <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_last_tick) begin
            r_divcnt <= '0;
            if (r_bitcnt == 3'd7) begin
              // Select returns to 000 in idle; data stays on D0..D7.
              r_state     <= ST_IDLE;
              r_idx       <= 3'd0;
              r_bitcnt    <= 3'd0;
              r_bit_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx        <= w_next_idx;
              r_bitcnt     <= r_bitcnt + 3'd1;
              r_bit_strobe <= 1'b1;
            end
          end else begin
            r_divcnt <= r_divcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign {D7, D6, D5, D4, D3, D2, D1, D0} = r_data;
  assign {S2, S1, S0} = r_idx;
  assign bit_valid  = r_bit_valid;
  assign bit_strobe = r_bit_strobe;
  assign done       = r_done;

endmodule

// File: tb/tb_mux_8x1_select_sequencer.sv
// tb/tb_mux_8x1_select_sequencer.sv - directed vector bench for the mux select sequencer
module tb_mux_8x1_select_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'd0;
  logic       in_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wire [7:0] d_a, d_b, d_c;
  wire [2:0] s_a, s_b, s_c;
  wire       bv_a, bv_b, bv_c, st_a, st_b, st_c, dn_a, dn_b, dn_c, rdy_a, rdy_b, rdy_c;

  // Packed view per instance: {ready, done, strobe, bit_valid, S[2:0], D[7:0]}
  wire [14:0] obs [3];
  assign obs[0] = {rdy_a, dn_a, st_a, bv_a, s_a, d_a};
  assign obs[1] = {rdy_b, dn_b, st_b, bv_b, s_b, d_b};
  assign obs[2] = {rdy_c, dn_c, st_c, bv_c, s_c, d_c};

  mux_8x1_select_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) u_lsb1 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_a),
    .D0(d_a[0]), .D1(d_a[1]), .D2(d_a[2]), .D3(d_a[3]),
    .D4(d_a[4]), .D5(d_a[5]), .D6(d_a[6]), .D7(d_a[7]),
    .S0(s_a[0]), .S1(s_a[1]), .S2(s_a[2]),
    .bit_valid(bv_a), .bit_strobe(st_a), .done(dn_a));

  mux_8x1_select_sequencer #(.DIV(1), .MSB_FIRST(1'b1)) u_msb1 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_b),
    .D0(d_b[0]), .D1(d_b[1]), .D2(d_b[2]), .D3(d_b[3]),
    .D4(d_b[4]), .D5(d_b[5]), .D6(d_b[6]), .D7(d_b[7]),
    .S0(s_b[0]), .S1(s_b[1]), .S2(s_b[2]),
    .bit_valid(bv_b), .bit_strobe(st_b), .done(dn_b));

  mux_8x1_select_sequencer #(.DIV(3), .MSB_FIRST(1'b0)) u_lsb3 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_c),
    .D0(d_c[0]), .D1(d_c[1]), .D2(d_c[2]), .D3(d_c[3]),
    .D4(d_c[4]), .D5(d_c[5]), .D6(d_c[6]), .D7(d_c[7]),
    .S0(s_c[0]), .S1(s_c[1]), .S2(s_c[2]),
    .bit_valid(bv_c), .bit_strobe(st_c), .done(dn_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input int inst);
    logic [14:0] o;
    o = obs[inst];
    chk("rst_data", o[7:0], 8'h00);
    chk("rst_sel", o[10:8], 3'd0);
    chk("rst_bit_valid", o[11], 1'b0);
    chk("rst_strobe", o[12], 1'b0);
    chk("rst_done", o[13], 1'b0);
    chk("rst_ready_low", o[14], 1'b0);
  endtask

  task automatic do_reset(input int inst, input bit valid_during);
    @(negedge clk);
    rst = 1'b1;
    in_valid = valid_during;
    din = 8'hFF;
    @(negedge clk);
    check_reset_outputs(inst);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", obs[inst][14], 1'b1);
    chk("post_rst_idle", obs[inst][11], 1'b0);
  endtask

  // seq[7] is the first mux output bit of the frame, seq[0] the last.
  task automatic run_frame(input int inst, input int div, input bit msb, input logic [7:0] b,
                           input logic [7:0] seq, input bit hold, input logic [7:0] nxt);
    logic [14:0] o;
    int idx;
    chk("accept_ready", obs[inst][14], 1'b1);
    din = b;
    in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (j == 0 && c == 0) begin
          if (hold) din = nxt;
          else in_valid = 1'b0;
        end
        o = obs[inst];
        idx = msb ? 7 - j : j;
        chk("sel", o[10:8], idx[2:0]);
        chk("bit_valid", o[11], 1'b1);
        chk("strobe", o[12], c == 0);
        chk("data_stable", o[7:0], b);
        chk("mux_out", o[o[10:8]], seq[7-j]);
        chk("done_early", o[13], 1'b0);
        chk("ready_busy", o[14], 1'b0);
      end
    end
    @(negedge clk);
    o = obs[inst];
    chk("done_pulse", o[13], 1'b1);
    chk("done_ready", o[14], 1'b1);
    chk("done_idle_bv", o[11], 1'b0);
    chk("done_idle_sel", o[10:8], 3'd0);
    chk("done_no_strobe", o[12], 1'b0);
    chk("done_data_hold", o[7:0], b);
  endtask

  typedef struct {
    int         inst;
    int         div;
    bit         msb;
    logic [7:0] din;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{inst: 0, div: 1, msb: 1'b0, din: 8'hA5, seq: 8'b10100101};
    vecs[1] = '{inst: 1, div: 1, msb: 1'b1, din: 8'hA5, seq: 8'b10100101};
    vecs[2] = '{inst: 1, div: 1, msb: 1'b1, din: 8'h01, seq: 8'b00000001};
    vecs[3] = '{inst: 2, div: 3, msb: 1'b0, din: 8'h0F, seq: 8'b11110000};
    vecs[4] = '{inst: 0, div: 1, msb: 1'b0, din: 8'h96, seq: 8'b01101001};

    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].inst, v == 0);
      run_frame(vecs[v].inst, vecs[v].div, vecs[v].msb, vecs[v].din, vecs[v].seq, 1'b0, 8'h00);
      @(negedge clk);
      chk("done_one_cycle", obs[vecs[v].inst][13], 1'b0);
      chk("idle_after_frame", obs[vecs[v].inst][11], 1'b0);
    end

    // Back-to-back: in_valid held high, second byte accepted in the done cycle.
    do_reset(0, 1'b0);
    run_frame(0, 1, 1'b0, 8'h3C, 8'b00111100, 1'b1, 8'hC3);
    run_frame(0, 1, 1'b0, 8'hC3, 8'b11000011, 1'b0, 8'h00);

    // Reset in the middle of bit 4 aborts the frame with no done pulse.
    do_reset(0, 1'b0);
    din = 8'h5A;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("mid_bit4_sel", obs[0][10:8], 3'd4);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", obs[0][14], 1'b1);
    chk("abort_no_done", obs[0][13], 1'b0);
    chk("abort_idle", obs[0][11], 1'b0);
    run_frame(0, 1, 1'b0, 8'h96, 8'b01101001, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
